// File: rtl/alu_pkg.sv
// Shared opcode/funct7 constants and operand-bundle layout for the ALU issue stage.
package alu_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned FUNCT3_W = 3;
    localparam int unsigned RD_W     = 5;

    typedef struct packed {
        logic [XLEN-1:0]     in1;
        logic [XLEN-1:0]     b;
        logic [FUNCT3_W-1:0] funct3;
        logic                upper;
        logic                lower;
        logic                cori;
        logic [RD_W-1:0]     rd;
    } alu_bundle_t;

    // Buffer occupancy: nothing, output register only, output register plus skid.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } buf_state_e;

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational RV32I decode of OP / OP-IMM / BRANCH into an ALU operand bundle.
module alu_issue_decode
    import alu_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] rs1_val,
    input  logic [31:0] rs2_val,
    output alu_bundle_t bundle,
    output logic        legal
);

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic       unused_rs1_field;

    assign opcode = instr[6:0];
    assign funct7 = instr[31:25];
    assign funct3 = instr[14:12];
    // Register index is resolved upstream; only the value is consumed here.
    assign unused_rs1_field = ^instr[19:15];

    // Select operand sources and check funct3/funct7 legality per opcode class.
    always_comb begin
        bundle = '0;
        legal  = 1'b0;
        case (opcode)
            OPC_OP: begin
                bundle.in1    = rs2_val;
                bundle.b      = rs1_val;
                bundle.funct3 = funct3;
                bundle.upper  = instr[30];
                bundle.lower  = 1'b1;
                bundle.cori   = 1'b0;
                bundle.rd     = instr[11:7];
                legal = (funct7 == F7_ZERO) ||
                        ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
            end
            OPC_OP_IMM: begin
                bundle.in1    = {{20{instr[31]}}, instr[31:20]};
                bundle.b      = rs1_val;
                bundle.funct3 = funct3;
                bundle.upper  = instr[30];
                bundle.lower  = 1'b0;
                bundle.cori   = 1'b0;
                bundle.rd     = instr[11:7];
                case (funct3)
                    3'b001:  legal = (funct7 == F7_ZERO);
                    3'b101:  legal = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
                    default: legal = 1'b1;
                endcase
            end
            OPC_BRANCH: begin
                bundle.in1    = rs2_val;
                bundle.b      = rs1_val;
                bundle.funct3 = funct3;
                bundle.upper  = 1'b0;
                bundle.lower  = 1'b1;
                bundle.cori   = 1'b1;
                bundle.rd     = '0;
                legal = (funct3 != 3'b010) && (funct3 != 3'b011);
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decode, two-entry skid buffering and illegal-instruction accounting.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int unsigned ILL_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          instr,
    input  logic [31:0]          rs1_val,
    input  logic [31:0]          rs2_val,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          alu_in1,
    output logic [31:0]          alu_b,
    output logic [2:0]           alu_funct3,
    output logic                 alu_upper,
    output logic                 alu_lower,
    output logic                 alu_cori,
    output logic [4:0]           alu_rd,
    output logic                 ill_pulse,
    output logic [ILL_CNT_W-1:0] ill_count
);

    alu_bundle_t          dec_bundle;
    logic                 dec_legal;
    logic                 accept;
    logic                 push;

    buf_state_e           state_q, state_d;
    alu_bundle_t          out_q, out_d;
    alu_bundle_t          skid_q, skid_d;
    logic                 ill_pulse_q, ill_pulse_d;
    logic [ILL_CNT_W-1:0] ill_count_q, ill_count_d;

    alu_issue_decode u_decode (
        .instr   (instr),
        .rs1_val (rs1_val),
        .rs2_val (rs2_val),
        .bundle  (dec_bundle),
        .legal   (dec_legal)
    );

    assign in_ready = (state_q != ST_TWO) && !rst;
    assign accept   = in_valid && in_ready;
    assign push     = accept && dec_legal;

    // Next-state for the output/skid pair and the illegal-instruction counter.
    always_comb begin
        state_d     = state_q;
        out_d       = out_q;
        skid_d      = skid_q;
        ill_pulse_d = accept && !dec_legal;
        ill_count_d = ill_count_q;
        if (accept && !dec_legal && (ill_count_q != '1)) begin
            ill_count_d = ill_count_q + ILL_CNT_W'(1);
        end
        case (state_q)
            ST_EMPTY: begin
                if (push) begin
                    out_d   = dec_bundle;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (push) begin
                    if (out_ready) begin
                        out_d = dec_bundle;
                    end else begin
                        skid_d  = dec_bundle;
                        state_d = ST_TWO;
                    end
                end else if (out_ready) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                // in_ready is low here, so only the skid-to-output move can happen.
                if (out_ready) begin
                    out_d   = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // State registers; reset discards both buffered entries immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            out_q       <= '0;
            skid_q      <= '0;
            ill_pulse_q <= 1'b0;
            ill_count_q <= '0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            skid_q      <= skid_d;
            ill_pulse_q <= ill_pulse_d;
            ill_count_q <= ill_count_d;
        end
    end

    assign out_valid  = (state_q != ST_EMPTY);
    assign alu_in1    = out_q.in1;
    assign alu_b      = out_q.b;
    assign alu_funct3 = out_q.funct3;
    assign alu_upper  = out_q.upper;
    assign alu_lower  = out_q.lower;
    assign alu_cori   = out_q.cori;
    assign alu_rd     = out_q.rd;
    assign ill_pulse  = ill_pulse_q;
    assign ill_count  = ill_count_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: vector table plus scoreboard of delivered bundles.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_in1;
    logic [31:0] alu_b;
    logic [2:0]  alu_funct3;
    logic        alu_upper;
    logic        alu_lower;
    logic        alu_cori;
    logic [4:0]  alu_rd;
    logic        ill_pulse;
    logic [7:0]  ill_count;

    always #5 clk = ~clk;

    alu_issue_stage #(.ILL_CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .instr      (instr),
        .rs1_val    (rs1_val),
        .rs2_val    (rs2_val),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu_in1    (alu_in1),
        .alu_b      (alu_b),
        .alu_funct3 (alu_funct3),
        .alu_upper  (alu_upper),
        .alu_lower  (alu_lower),
        .alu_cori   (alu_cori),
        .alu_rd     (alu_rd),
        .ill_pulse  (ill_pulse),
        .ill_count  (ill_count)
    );

    typedef struct {
        logic [31:0] in1;
        logic [31:0] b;
        logic [2:0]  f3;
        logic        upper;
        logic        lower;
        logic        cori;
        logic [4:0]  rd;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        legal;
        exp_t        e;
    } vec_t;

    exp_t  sb[$];
    vec_t  tbl[16];
    int    checks = 0;
    int    errors = 0;
    int    exp_ill = 0;
    logic  pulse_due = 1'b0;
    logic  rand_ready = 1'b0;
    logic  held_v = 1'b0;
    logic [77:0] held_b;

    function automatic vec_t mk(input logic [31:0] i, input logic [31:0] r1, input logic [31:0] r2,
                                input logic lg, input logic [31:0] in1, input logic [31:0] b,
                                input logic [2:0] f3, input logic up, input logic lo,
                                input logic co, input logic [4:0] rd);
        vec_t v;
        v.instr = i; v.rs1 = r1; v.rs2 = r2; v.legal = lg;
        v.e.in1 = in1; v.e.b = b; v.e.f3 = f3; v.e.upper = up;
        v.e.lower = lo; v.e.cori = co; v.e.rd = rd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [77:0] cur_bundle();
        return {alu_in1, alu_b, alu_funct3, alu_upper, alu_lower, alu_cori, alu_rd};
    endfunction

    // Monitor: pulse timing, hold stability, and in-order delivery against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                held_v = 1'b0;
            end else begin
                chk("ill_pulse", {63'd0, ill_pulse}, {63'd0, pulse_due});
                pulse_due = 1'b0;
                if (out_valid && !out_ready) begin
                    if (held_v) begin
                        checks++;
                        if (cur_bundle() !== held_b) begin
                            errors++;
                            $display("FAIL hold_stable actual=%0h required=%0h", cur_bundle(), held_b);
                        end
                    end
                    held_v = 1'b1;
                    held_b = cur_bundle();
                end else begin
                    held_v = 1'b0;
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_out actual=%0h required=none", alu_in1);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        checks++;
                        if (cur_bundle() !== {e.in1, e.b, e.f3, e.upper, e.lower, e.cori, e.rd}) begin
                            errors++;
                            $display("FAIL bundle actual=%0h required=%0h", cur_bundle(),
                                     {e.in1, e.b, e.f3, e.upper, e.lower, e.cori, e.rd});
                        end
                    end
                end
            end
        end
    end

    // Random out_ready pattern for the back-pressure pass.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send(input vec_t v, output int waits);
        int n;
        n = 0;
        in_valid = 1'b1;
        instr    = v.instr;
        rs1_val  = v.rs1;
        rs2_val  = v.rs2;
        @(negedge clk);
        while (!in_ready && n < 60) begin
            n++;
            @(negedge clk);
        end
        waits = n;
        if (!in_ready) begin
            chk("accept_timeout", 64'd0, 64'd1);
            in_valid = 1'b0;
            return;
        end
        if (v.legal) sb.push_back(v.e);
        @(posedge clk);
        if (!v.legal) begin
            pulse_due = 1'b1;
            if (exp_ill < 255) exp_ill++;
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int w;
        int idx;
        tbl[0]  = mk(32'hFFF10093, 32'd5, 32'd0, 1, 32'hFFFFFFFF, 32'd5, 3'b000, 1, 0, 0, 5'd1);  // ADDI -1
        tbl[1]  = mk(32'h40208033, 32'd10, 32'd3, 1, 32'd3, 32'd10, 3'b000, 1, 1, 0, 5'd0);       // SUB
        tbl[2]  = mk(32'h0020C063, 32'hFFFFFFFE, 32'd1, 1, 32'd1, 32'hFFFFFFFE, 3'b100, 0, 1, 1, 5'd0); // BLT
        tbl[3]  = mk(32'h002081B3, 32'd7, 32'd9, 1, 32'd9, 32'd7, 3'b000, 0, 1, 0, 5'd3);          // ADD
        tbl[4]  = mk(32'h40335293, 32'h80000000, 32'd1, 1, 32'h00000403, 32'h80000000, 3'b101, 1, 0, 0, 5'd5); // SRAI
        tbl[5]  = mk(32'h00409113, 32'h12345678, 32'd2, 1, 32'd4, 32'h12345678, 3'b001, 0, 0, 0, 5'd2); // SLLI
        tbl[6]  = mk(32'h8000A213, 32'd42, 32'd0, 1, 32'hFFFFF800, 32'd42, 3'b010, 0, 0, 0, 5'd4);  // SLTI -2048
        tbl[7]  = mk(32'h00208063, 32'hA5A5A5A5, 32'h5A5A5A5A, 1, 32'h5A5A5A5A, 32'hA5A5A5A5, 3'b000, 0, 1, 1, 5'd0); // BEQ
        tbl[8]  = mk(32'h403150B3, 32'hF0000000, 32'd4, 1, 32'd4, 32'hF0000000, 3'b101, 1, 1, 0, 5'd1); // SRA
        tbl[9]  = mk(32'h0000007F, 32'd1, 32'd1, 0, 0, 0, 0, 0, 0, 0, 0);  // unknown opcode
        tbl[10] = mk(32'h00002063, 32'd1, 32'd1, 0, 0, 0, 0, 0, 0, 0, 0);  // BRANCH f3=010
        tbl[11] = mk(32'h40001033, 32'd1, 32'd1, 0, 0, 0, 0, 0, 0, 0, 0);  // OP alt f3=001
        tbl[12] = mk(32'h40001013, 32'd1, 32'd1, 0, 0, 0, 0, 0, 0, 0, 0);  // OP-IMM f3=001 alt f7
        tbl[13] = mk(32'h02005013, 32'd1, 32'd1, 0, 0, 0, 0, 0, 0, 0, 0);  // OP-IMM f3=101 f7=0000001
        tbl[14] = mk(32'h02000033, 32'd1, 32'd1, 0, 0, 0, 0, 0, 0, 0, 0);  // OP f7=0000001
        tbl[15] = mk(32'h00003063, 32'd1, 32'd1, 0, 0, 0, 0, 0, 0, 0, 0);  // BRANCH f3=011

        rst = 1'b1; in_valid = 1'b0; instr = '0; rs1_val = '0; rs2_val = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_ill_count", {56'd0, ill_count}, 64'd0);
        chk("rst_ill_pulse", {63'd0, ill_pulse}, 64'd0);
        chk("rst_bundle_zero", {32'd0, alu_in1 | alu_b}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Table pass: full throughput with out_ready held high.
        for (int i = 0; i < 16; i++) begin
            send(tbl[i], w);
            chk("no_stall", 64'(w), 64'd0);
            if (i == 0) begin
                chk("addi_latency", {63'd0, out_valid}, 64'd1);
                chk("addi_in1", {32'd0, alu_in1}, 64'hFFFFFFFF);
            end
        end
        repeat (2) @(posedge clk);
        #1;
        chk("ill_count_table", {56'd0, ill_count}, 64'(exp_ill));
        chk("idle_out_valid", {63'd0, out_valid}, 64'd0);
        wait_drain();

        // Opcode 0x7F then BRANCH f3=010: two strobes, no output, count +2.
        idx = exp_ill;
        send(tbl[9], w);
        send(tbl[10], w);
        repeat (2) @(posedge clk);
        #1;
        chk("two_illegal_count", {56'd0, ill_count}, 64'(idx + 2));
        chk("two_illegal_no_out", {63'd0, out_valid}, 64'd0);

        // Back-pressure: A in output, B in skid, C held upstream.
        out_ready = 1'b0;
        send(tbl[3], w);
        send(tbl[4], w);
        fork
            send(tbl[5], w);
            begin
                @(negedge clk);
                chk("skid_full_in_ready", {63'd0, in_ready}, 64'd0);
                chk("skid_full_out_valid", {63'd0, out_valid}, 64'd1);
                chk("skid_full_head", {32'd0, alu_in1}, 64'd9);
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_drain();

        // Random back-pressure with legal and illegal mix.
        rand_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            idx = $urandom_range(0, 15);
            send(tbl[idx], w);
        end
        rand_ready = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        wait_drain();

        // Saturation of the illegal counter.
        for (int k = 0; k < 300; k++) send(tbl[9 + (k % 7)], w);
        repeat (2) @(posedge clk);
        #1;
        chk("ill_count_model", {56'd0, ill_count}, 64'(exp_ill));
        chk("ill_count_sat", {56'd0, ill_count}, 64'd255);

        // Reset with output and skid both occupied.
        out_ready = 1'b0;
        send(tbl[1], w);
        send(tbl[2], w);
        #2 rst = 1'b1;
        #1;
        chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("midrst_ill_count", {56'd0, ill_count}, 64'd0);
        chk("midrst_bundle_zero", {32'd0, alu_in1}, 64'd0);
        sb.delete();
        exp_ill = 0;
        pulse_due = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        send(tbl[6], w);
        chk("post_rst_no_stall", 64'(w), 64'd0);
        chk("post_rst_latency", {63'd0, out_valid}, 64'd1);
        chk("post_rst_in1", {32'd0, alu_in1}, 64'hFFFFF800);
        wait_drain();
        repeat (2) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global guard so the run always ends.
    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
